// File: rtl/disp_pkg.sv
// Shared display-path definitions: scheduler states and 720p timing constants.
package disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_D,
    WAIT_D,
    REQ_C,
    WAIT_C
  } sched_state_t;

  localparam int H_ACTIVE    = 1280;
  localparam int V_ACTIVE    = 720;
  localparam int V_ACT_START = 25;
  localparam int BURST_LEN   = 64;
  localparam int BURSTS      = H_ACTIVE / BURST_LEN;

endpackage

// File: rtl/disp_addr_gen.sv
// Row/burst counters for the display fetch. The burst address is kept as a
// running sum so no multiplier is needed; everything wraps modulo 2^ADDR_W.
module disp_addr_gen #(
  parameter int ADDR_W      = 24,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 1280,
  parameter int BURST_LEN   = 64,
  parameter int BURSTS      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              first,
  input  logic              advance,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              last_burst
);

  localparam int IDX_W = $clog2(BURSTS + 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0] BSTEP  = ADDR_W'(BURST_LEN);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_row;
  logic [IDX_W-1:0]  burst_idx;

  assign next_row   = first ? BASE : row_base + STRIDE;
  assign last_burst = (burst_idx == IDX_W'(BURSTS - 1));

  // A new line restarts at its row base; it takes priority over a completing burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base  <= BASE;
      disp_addr <= BASE;
      burst_idx <= '0;
    end else if (start) begin
      row_base  <= next_row;
      disp_addr <= next_row;
      burst_idx <= '0;
    end else if (advance) begin
      disp_addr <= disp_addr + BSTEP;
      burst_idx <= burst_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/disp_mem_sched.sv
// Shared framebuffer port scheduler: fetches each active line as a series of
// display bursts and interleaves generic client bursts with bounded starvation.
module disp_mem_sched
  import disp_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 1280,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [11:0]       v_cnt,
  input  logic              cl_req,
  input  logic [ADDR_W-1:0] cl_addr,
  input  logic              cl_we,
  output logic              cl_gnt,
  output logic              cl_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_src,
  input  logic              mem_ack,
  input  logic              mem_done,
  output logic              buf_sel,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [ST_W-1:0] STARVE_TOP = ST_W'(STARVE_MAX);
  localparam logic [11:0] V_FIRST = 12'(V_ACT_START - 1);
  localparam logic [11:0] V_END   = 12'(V_ACT_START + V_ACTIVE - 1);

  sched_state_t      state;
  logic              pending;
  logic              stale;
  logic [ST_W-1:0]   starve;
  logic [ADDR_W-1:0] disp_addr;
  logic              last_burst;
  logic              line_ok;
  logic              start_line;
  logic              first_line;
  logic              disp_done;
  logic              advance;
  logic              final_done;
  logic              still_pending;
  logic              set_stale;

  assign line_ok    = (v_cnt >= V_FIRST) && (v_cnt < V_END);
  assign start_line = line_start && line_ok;
  assign first_line = (v_cnt == V_FIRST);

  // A burst that was already issued when its line got dropped must not move
  // the new line's counters; 'stale' marks that burst.
  assign disp_done     = (state == WAIT_D) && mem_done;
  assign advance       = disp_done && !stale;
  assign final_done    = advance && last_burst;
  assign still_pending = pending && !final_done;
  assign set_stale     = line_start && pending &&
                         ((state == REQ_D) || ((state == WAIT_D) && !mem_done));

  assign fetch_busy = pending || (state == REQ_D) || (state == WAIT_D);
  assign cl_gnt     = (state == REQ_C) && mem_ack;

  disp_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FB_BASE     (FB_BASE),
    .LINE_STRIDE (LINE_STRIDE),
    .BURST_LEN   (BURST_LEN),
    .BURSTS      (BURSTS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (start_line),
    .first      (first_line),
    .advance    (advance),
    .disp_addr  (disp_addr),
    .last_burst (last_burst)
  );

  // Line bookkeeping: pending work, buffer half, underrun flag and stale-burst marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      stale    <= 1'b0;
      buf_sel  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= line_start && still_pending;
      if (line_start) begin
        pending <= line_ok;
      end else if (final_done) begin
        pending <= 1'b0;
      end
      if (start_line) begin
        buf_sel <= ~buf_sel;
      end
      if (set_stale) begin
        stale <= 1'b1;
      end else if (disp_done) begin
        stale <= 1'b0;
      end
    end
  end

  // Arbitration FSM: one burst outstanding, display first unless the client is starved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      starve   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_src  <= 1'b0;
      cl_done  <= 1'b0;
    end else begin
      cl_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && !line_start && !(cl_req && (starve == STARVE_TOP))) begin
            state    <= REQ_D;
            mem_req  <= 1'b1;
            mem_addr <= disp_addr;
            mem_we   <= 1'b0;
            mem_src  <= 1'b0;
          end else if (cl_req) begin
            state    <= REQ_C;
            mem_req  <= 1'b1;
            mem_addr <= cl_addr;
            mem_we   <= cl_we;
            mem_src  <= 1'b1;
          end
        end
        REQ_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (mem_done) begin
            state <= IDLE;
            if (cl_req && (starve != STARVE_TOP)) begin
              starve <= starve + ST_W'(1);
            end
          end
        end
        REQ_C: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WAIT_C;
          end
        end
        WAIT_C: begin
          if (mem_done) begin
            cl_done <= 1'b1;
            starve  <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_mem_sched.sv
// Self-checking bench for disp_mem_sched: memory responder with a burst
// scoreboard, a client driver, and table-driven line tests plus corner sequences.
module tb_disp_mem_sched;
  import disp_pkg::*;

  localparam int ACK_DLY  = 4;
  localparam int DONE_DLY = 4;
  localparam int LIMIT    = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [11:0] v_cnt;
  logic        cl_req;
  logic [23:0] cl_addr;
  logic        cl_we;
  logic        cl_gnt;
  logic        cl_done;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic        mem_src;
  logic        mem_ack;
  logic        mem_done;
  logic        buf_sel;
  logic        fetch_busy;
  logic        underrun;

  typedef struct {
    logic        src;
    logic        we;
    logic [23:0] addr;
  } burst_t;

  typedef struct {
    logic [11:0] v;
    logic        fetch;
    logic [23:0] row;
    logic        buf_exp;
  } line_vec_t;

  burst_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int cl_done_cnt = 0;
  int underrun_cnt = 0;
  int phase = 0;
  int cnt = 0;
  int done_budget = -1;
  int cl_target = 0;
  int cl_epoch = 0;
  int drv_epoch = 0;
  int cl_k = 0;

  always #5 clk = ~clk;

  disp_mem_sched #(
    .ADDR_W      (24),
    .FB_BASE     (0),
    .LINE_STRIDE (1280),
    .STARVE_MAX  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .v_cnt      (v_cnt),
    .cl_req     (cl_req),
    .cl_addr    (cl_addr),
    .cl_we      (cl_we),
    .cl_gnt     (cl_gnt),
    .cl_done    (cl_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_src    (mem_src),
    .mem_ack    (mem_ack),
    .mem_done   (mem_done),
    .buf_sel    (buf_sel),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  function automatic logic [23:0] client_addr(input int k);
    return 24'h100000 + 24'(k * 64);
  endfunction

  function automatic logic client_we(input int k);
    logic [31:0] kk;
    kk = k;
    return kk[0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [23:0] row, input int n);
    burst_t e;
    for (int i = 0; i < n; i++) begin
      e.src  = 1'b0;
      e.we   = 1'b0;
      e.addr = row + 24'(i * 64);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_client(input int k);
    burst_t e;
    e.src  = 1'b1;
    e.we   = client_we(k);
    e.addr = client_addr(k);
    exp_q.push_back(e);
  endtask

  // Compare an accepted burst against the head of the scoreboard.
  task automatic score_burst();
    burst_t e;
    ack_cnt++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_burst: got addr 0x%0h src %0d, expected no burst", mem_addr, mem_src);
    end else begin
      e = exp_q.pop_front();
      check_output("burst_addr", mem_addr, e.addr);
      check_output("burst_src", mem_src, e.src);
      check_output("burst_we", mem_we, e.we);
      check_output("cl_gnt_with_ack", cl_gnt, e.src);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] v);
    @(negedge clk);
    v_cnt      = v;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (i < LIMIT && !(exp_q.size() == 0 && phase == 0 && !mem_req && !fetch_busy && !cl_req)) begin
      @(negedge clk);
      #2;
      i++;
    end
    checks++;
    if (i >= LIMIT) begin
      errors++;
      $display("[TB] FAIL %s_drain: waited %0d cycles with %0d bursts outstanding, required drain within %0d", name, i, exp_q.size(), LIMIT);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acks(input string name, input int target);
    int i;
    i = 0;
    while (i < LIMIT && ack_cnt < target) begin
      @(negedge clk);
      #2;
      i++;
    end
    checks++;
    if (ack_cnt < target) begin
      errors++;
      $display("[TB] FAIL %s_acks: got %0d bursts, required %0d", name, ack_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_req"}, mem_req, 0);
    check_output({tag, "_mem_addr"}, mem_addr, 0);
    check_output({tag, "_mem_we"}, mem_we, 0);
    check_output({tag, "_mem_src"}, mem_src, 0);
    check_output({tag, "_cl_gnt"}, cl_gnt, 0);
    check_output({tag, "_cl_done"}, cl_done, 0);
    check_output({tag, "_buf_sel"}, buf_sel, 0);
    check_output({tag, "_fetch_busy"}, fetch_busy, 0);
    check_output({tag, "_underrun"}, underrun, 0);
  endtask

  // Memory controller model: ack ACK_DLY cycles after a request, done DONE_DLY later.
  initial begin
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_done = 1'b0;
      if (rst) begin
        phase = 0;
        cnt   = 0;
      end else begin
        case (phase)
          0: if (mem_req) begin
            phase = 1;
            cnt   = 0;
          end
          1: begin
            cnt++;
            if (cnt == ACK_DLY) begin
              mem_ack = 1'b1;
              #1;
              score_burst();
              phase = 2;
              cnt   = 0;
            end
          end
          default: begin
            if (cnt < DONE_DLY) cnt++;
            if (cnt >= DONE_DLY && done_budget != 0) begin
              mem_done = 1'b1;
              done_cnt++;
              if (done_budget > 0) done_budget--;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Client driver: issues cl_target bursts per epoch, advancing on each grant.
  initial begin
    cl_req  = 1'b0;
    cl_addr = '0;
    cl_we   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (cl_epoch != drv_epoch) begin
        drv_epoch = cl_epoch;
        cl_k      = 0;
      end else if (cl_gnt) begin
        cl_k++;
      end
      cl_req  = (cl_k < cl_target);
      cl_addr = client_addr(cl_k);
      cl_we   = client_we(cl_k);
    end
  end

  // Pulse counters for cl_done and underrun.
  initial begin
    forever begin
      @(negedge clk);
      if (cl_done) cl_done_cnt++;
      if (underrun) underrun_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    line_vec_t lines[5];
    int a0;
    int c0;
    int u0;

    lines[0] = '{12'd24,  1'b1, 24'd0,    1'b1};
    lines[1] = '{12'd25,  1'b1, 24'd1280, 1'b0};
    lines[2] = '{12'd744, 1'b0, 24'd0,    1'b0};
    lines[3] = '{12'd10,  1'b0, 24'd0,    1'b0};
    lines[4] = '{12'd26,  1'b1, 24'd2560, 1'b1};

    rst        = 1'b1;
    line_start = 1'b0;
    v_cnt      = 12'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    $display("[TB] line fetch table");
    for (int t = 0; t < 5; t++) begin
      a0 = ack_cnt;
      if (lines[t].fetch) push_line(lines[t].row, BURSTS);
      apply_stimulus(lines[t].v);
      check_output("fetch_busy_after_line_start", fetch_busy, lines[t].fetch);
      check_output("buf_sel_after_line_start", buf_sel, lines[t].buf_exp);
      if (lines[t].fetch) wait_drain("line");
      else repeat (30) @(negedge clk);
      check_output("bursts_per_line", ack_cnt - a0, lines[t].fetch ? BURSTS : 0);
    end
    check_output("no_underrun_in_table", underrun_cnt, 0);
    check_output("no_cl_done_in_table", cl_done_cnt, 0);

    $display("[TB] client interleave during fetch");
    a0 = ack_cnt;
    c0 = cl_done_cnt;
    for (int g = 0; g < 5; g++) begin
      push_line(24'd3840 + 24'(g * 4 * 64), 4);
      push_client(g);
    end
    apply_stimulus(12'd27);
    cl_target = 5;
    cl_epoch++;
    check_output("buf_sel_line27", buf_sel, 0);
    wait_drain("interleave");
    check_output("interleave_bursts", ack_cnt - a0, 25);
    check_output("interleave_cl_done", cl_done_cnt - c0, 5);

    $display("[TB] client-only traffic in blanking");
    a0 = ack_cnt;
    c0 = cl_done_cnt;
    for (int k = 0; k < 3; k++) push_client(k);
    @(negedge clk);
    v_cnt     = 12'd10;
    cl_target = 3;
    cl_epoch++;
    wait_drain("client_only");
    check_output("client_only_bursts", ack_cnt - a0, 3);
    check_output("client_only_cl_done", cl_done_cnt - c0, 3);
    check_output("client_only_buf_sel", buf_sel, 0);

    $display("[TB] underrun with stalled burst");
    a0 = ack_cnt;
    u0 = underrun_cnt;
    done_budget = 10;
    push_line(24'd5120, 11);
    apply_stimulus(12'd28);
    check_output("buf_sel_line28", buf_sel, 1);
    wait_acks("stall", a0 + 11);
    repeat (2) @(negedge clk);
    push_line(24'd6400, BURSTS);
    apply_stimulus(12'd29);
    check_output("underrun_pulse", underrun, 1);
    check_output("fetch_busy_after_underrun", fetch_busy, 1);
    check_output("buf_sel_line29", buf_sel, 0);
    @(negedge clk);
    check_output("underrun_one_cycle", underrun, 0);
    done_budget = -1;
    wait_drain("underrun");
    check_output("underrun_count", underrun_cnt - u0, 1);
    check_output("underrun_total_bursts", ack_cnt - a0, 11 + BURSTS);

    $display("[TB] async reset during display burst");
    a0 = ack_cnt;
    push_line(24'd0, 3);
    apply_stimulus(12'd24);
    wait_acks("pre_reset", a0 + 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midburst_reset");
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    a0 = ack_cnt;
    push_line(24'd0, BURSTS);
    apply_stimulus(12'd24);
    check_output("buf_sel_after_reset_line", buf_sel, 1);
    wait_drain("post_reset");
    check_output("post_reset_bursts", ack_cnt - a0, BURSTS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
